// File: rtl/dsp_flow_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dsp_flow_pkg
// Brief    : Flow-control codes shared between decode and branch resolution.
// Revision : 1.0
// ============================================================================
package dsp_flow_pkg;

    localparam int FLOW_MODE_LEN = 4;

    typedef enum logic [FLOW_MODE_LEN-1:0] {
        FLOW_NONE = 4'd0,
        FLOW_JMP  = 4'd1,
        FLOW_BEZ  = 4'd2,
        FLOW_BNEZ = 4'd3,
        FLOW_BEQ  = 4'd4,
        FLOW_BLTZ = 4'd5,
        FLOW_CALL = 4'd6,
        FLOW_RET  = 4'd7,
        FLOW_LSET = 4'd8,
        FLOW_LOOP = 4'd9
    } flow_e;

    // Outcome of the ALU-conditioned branches; other modes report not-taken.
    function automatic logic cond_taken(input flow_e mode, input logic is_zero,
                                        input logic is_neg);
        logic taken;
        taken = 1'b0;
        case (mode)
            FLOW_BEZ, FLOW_BEQ: taken = is_zero;
            FLOW_BNEZ:          taken = !is_zero;
            FLOW_BLTZ:          taken = is_neg;
            default:            taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dsp_ret_stack.sv
`default_nettype none
// ============================================================================
// Module   : dsp_ret_stack
// Brief    : LIFO return-address stack; pointer counts occupied entries.
// Revision : 1.0
// ============================================================================
module dsp_ret_stack #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W-1:0] top
);

    localparam int PTR_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [ADDR_W-1:0] mem_q [DEPTH];

    assign full  = (ptr_q == PTR_W'(DEPTH));
    assign empty = (ptr_q == '0);

    always_comb begin
        ptr_d = ptr_q;
        if (push && !full) begin
            ptr_d = ptr_q + PTR_W'(1);
        end else if (pop && !empty) begin
            ptr_d = ptr_q - PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_entry
            logic [ADDR_W-1:0] mem_d;

            always_comb begin
                mem_d = mem_q[i];
                if (push && !full && (ptr_q == PTR_W'(i))) begin
                    mem_d = push_data;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mem_q[i] <= '0;
                end else begin
                    mem_q[i] <= mem_d;
                end
            end
        end
    endgenerate

    // Mux by comparison keeps the read free of out-of-range indexing when empty.
    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ptr_q == PTR_W'(i + 1)) begin
                top = mem_q[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dsp_branch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dsp_branch_ctrl
// Brief    : Registered branch resolution with return stack, loop counter, flush.
// Revision : 1.0
// ============================================================================
module dsp_branch_ctrl
    import dsp_flow_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 16,
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     valid_in,
    input  logic [FLOW_MODE_LEN-1:0] flow_mode,
    input  logic [DATA_W-1:0]        alu_result,
    input  logic [ADDR_W-1:0]        target_addr,
    input  logic [ADDR_W-1:0]        pc_next,
    input  logic [DATA_W-1:0]        loop_count,
    output logic                     jump_flag,
    output logic [ADDR_W-1:0]        jump_addr,
    output logic                     flush,
    output logic                     busy,
    output logic                     stack_err
);

    localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

    logic              jump_flag_q, jump_flag_d;
    logic [ADDR_W-1:0] jump_addr_q, jump_addr_d;
    logic              stack_err_q, stack_err_d;
    logic [DATA_W-1:0] loop_cnt_q,  loop_cnt_d;
    logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;

    logic              accept;
    logic              taken;
    logic [ADDR_W-1:0] target;
    logic              push;
    logic              pop;
    logic              stk_full;
    logic              stk_empty;
    logic [ADDR_W-1:0] stk_top;
    flow_e             mode;

    dsp_ret_stack #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ret_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .push_data (pc_next),
        .full      (stk_full),
        .empty     (stk_empty),
        .top       (stk_top)
    );

    assign busy   = (flush_cnt_q != '0);
    assign accept = valid_in && !busy;
    assign mode   = flow_e'(flow_mode);

    always_comb begin
        taken       = 1'b0;
        target      = target_addr;
        push        = 1'b0;
        pop         = 1'b0;
        loop_cnt_d  = loop_cnt_q;
        stack_err_d = stack_err_q;

        if (accept) begin
            case (mode)
                FLOW_JMP: taken = 1'b1;
                FLOW_BEZ, FLOW_BEQ, FLOW_BNEZ, FLOW_BLTZ: begin
                    taken = cond_taken(mode, (alu_result == '0), alu_result[DATA_W-1]);
                end
                // A CALL on a full stack still jumps; only the push is dropped.
                FLOW_CALL: begin
                    taken = 1'b1;
                    if (stk_full) begin
                        stack_err_d = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end
                FLOW_RET: begin
                    if (stk_empty) begin
                        stack_err_d = 1'b1;
                    end else begin
                        pop    = 1'b1;
                        taken  = 1'b1;
                        target = stk_top;
                    end
                end
                FLOW_LSET: loop_cnt_d = loop_count;
                FLOW_LOOP: begin
                    if (loop_cnt_q != '0) begin
                        loop_cnt_d = loop_cnt_q - DATA_W'(1);
                        taken      = 1'b1;
                    end
                end
                default: taken = 1'b0;
            endcase
        end

        jump_flag_d = taken;
        jump_addr_d = taken ? target : jump_addr_q;

        if (taken) begin
            flush_cnt_d = FC_W'(FLUSH_CYCLES);
        end else if (flush_cnt_q != '0) begin
            flush_cnt_d = flush_cnt_q - FC_W'(1);
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            jump_flag_q <= 1'b0;
            jump_addr_q <= '0;
            stack_err_q <= 1'b0;
            loop_cnt_q  <= '0;
            flush_cnt_q <= '0;
        end else begin
            jump_flag_q <= jump_flag_d;
            jump_addr_q <= jump_addr_d;
            stack_err_q <= stack_err_d;
            loop_cnt_q  <= loop_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign jump_flag = jump_flag_q;
    assign jump_addr = jump_addr_q;
    assign flush     = busy;
    assign stack_err = stack_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dsp_branch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsp_branch_ctrl
// Brief    : Scoreboard bench for dsp_branch_ctrl against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_dsp_branch_ctrl;
    import dsp_flow_pkg::*;

    localparam int DATA_W       = 16;
    localparam int ADDR_W       = 16;
    localparam int DEPTH        = 4;
    localparam int FLUSH_CYCLES = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              valid_in;
    logic [3:0]        flow_mode;
    logic [DATA_W-1:0] alu_result;
    logic [ADDR_W-1:0] target_addr;
    logic [ADDR_W-1:0] pc_next;
    logic [DATA_W-1:0] loop_count;
    logic              jump_flag;
    logic [ADDR_W-1:0] jump_addr;
    logic              flush;
    logic              busy;
    logic              stack_err;

    dsp_branch_ctrl #(
        .DATA_W       (DATA_W),
        .ADDR_W       (ADDR_W),
        .DEPTH        (DEPTH),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_in    (valid_in),
        .flow_mode   (flow_mode),
        .alu_result  (alu_result),
        .target_addr (target_addr),
        .pc_next     (pc_next),
        .loop_count  (loop_count),
        .jump_flag   (jump_flag),
        .jump_addr   (jump_addr),
        .flush       (flush),
        .busy        (busy),
        .stack_err   (stack_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              jf;
        logic [ADDR_W-1:0] ja;
        logic              fl;
        logic              er;
    } exp_t;

    exp_t              sb_q[$];
    logic [ADDR_W-1:0] m_stk[$];
    int unsigned       m_loop;
    int                m_flush;
    logic [ADDR_W-1:0] m_ja;
    logic              m_err;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_stk.delete();
        sb_q.delete();
        m_loop  = 0;
        m_flush = 0;
        m_ja    = '0;
        m_err   = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic [3:0] m, input logic [15:0] alu,
                              input logic [15:0] tgt, input logic [15:0] pc,
                              input logic [15:0] lc);
        logic        tk;
        logic [15:0] addr;
        exp_t        e;
        tk   = 1'b0;
        addr = tgt;
        if (v && m_flush == 0) begin
            case (m)
                4'd1: tk = 1'b1;
                4'd2, 4'd4: tk = (alu == 16'h0);
                4'd3: tk = (alu != 16'h0);
                4'd5: tk = alu[15];
                4'd6: begin
                    tk = 1'b1;
                    if (m_stk.size() >= DEPTH) m_err = 1'b1;
                    else m_stk.push_back(pc);
                end
                4'd7: begin
                    if (m_stk.size() == 0) m_err = 1'b1;
                    else begin
                        tk   = 1'b1;
                        addr = m_stk.pop_back();
                    end
                end
                4'd8: m_loop = lc;
                4'd9: if (m_loop != 0) begin
                    m_loop = m_loop - 1;
                    tk     = 1'b1;
                end
                default: tk = 1'b0;
            endcase
        end
        if (tk) begin
            m_ja    = addr;
            m_flush = FLUSH_CYCLES;
        end else if (m_flush > 0) begin
            m_flush = m_flush - 1;
        end
        e.jf = tk;
        e.ja = m_ja;
        e.fl = (m_flush != 0);
        e.er = m_err;
        sb_q.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        check("sb_pending", sb_q.size(), 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("jump_flag", jump_flag, e.jf);
            check("jump_addr", jump_addr, e.ja);
            check("flush",     flush,     e.fl);
            check("busy",      busy,      e.fl);
            check("stack_err", stack_err, e.er);
        end
    endtask

    task automatic cyc(input logic v, input logic [3:0] m, input logic [15:0] alu,
                       input logic [15:0] tgt, input logic [15:0] pc, input logic [15:0] lc);
        valid_in    = v;
        flow_mode   = m;
        alu_result  = alu;
        target_addr = tgt;
        pc_next     = pc;
        loop_count  = lc;
        model_step(v, m, alu, tgt, pc, lc);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 4'd0, 16'h0, 16'h0, 16'h0, 16'h0);
    endtask

    // Issue one instruction, then let any flush window drain.
    task automatic issue(input logic [3:0] m, input logic [15:0] alu, input logic [15:0] tgt,
                         input logic [15:0] pc, input logic [15:0] lc);
        cyc(1'b1, m, alu, tgt, pc, lc);
        idle(FLUSH_CYCLES);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_jf"}, jump_flag, 1'b0);
        check({tag, "_ja"}, jump_addr, 16'h0);
        check({tag, "_fl"}, flush,     1'b0);
        check({tag, "_bz"}, busy,      1'b0);
        check({tag, "_er"}, stack_err, 1'b0);
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        valid_in    = 1'b0;
        flow_mode   = 4'd0;
        alu_result  = '0;
        target_addr = '0;
        pc_next     = '0;
        loop_count  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        check_all_zero("reset");
    endtask

    initial begin
        do_reset();

        // Conditional branches
        issue(FLOW_BNEZ, 16'h0000, 16'h0040, 16'h0, 16'h0);
        cyc(1'b1, FLOW_BNEZ, 16'h0001, 16'h0040, 16'h0, 16'h0);
        // JMP held valid through the busy window
        cyc(1'b1, FLOW_JMP, 16'h0, 16'h0100, 16'h0, 16'h0);
        cyc(1'b1, FLOW_JMP, 16'h0, 16'h0100, 16'h0, 16'h0);
        cyc(1'b1, FLOW_JMP, 16'h0, 16'h0100, 16'h0, 16'h0);
        idle(FLUSH_CYCLES);
        issue(FLOW_BEZ,  16'h0000, 16'h0050, 16'h0, 16'h0);
        issue(FLOW_BEQ,  16'h0005, 16'h0055, 16'h0, 16'h0);
        issue(FLOW_BLTZ, 16'h8000, 16'h0060, 16'h0, 16'h0);
        issue(FLOW_BLTZ, 16'h7FFF, 16'h0066, 16'h0, 16'h0);
        issue(4'hF,      16'h0000, 16'h0070, 16'h0, 16'h0);

        // CALL / RET / underflow
        issue(FLOW_CALL, 16'h0, 16'h0200, 16'h0011, 16'h0);
        issue(FLOW_RET,  16'h0, 16'h0000, 16'h0000, 16'h0);
        issue(FLOW_RET,  16'h0, 16'h0000, 16'h0000, 16'h0);
        issue(FLOW_NONE, 16'h0, 16'h0000, 16'h0000, 16'h0);

        // Overflow on the fifth CALL, then unwind
        do_reset();
        for (int i = 0; i < 5; i++) begin
            issue(FLOW_CALL, 16'h0, 16'(16'h2000 + i), 16'(16'h1000 + i), 16'h0);
        end
        for (int i = 0; i < 5; i++) begin
            issue(FLOW_RET, 16'h0, 16'h0, 16'h0, 16'h0);
        end

        // Hardware loop
        do_reset();
        cyc(1'b1, FLOW_LSET, 16'h0, 16'h0, 16'h0, 16'd3);
        for (int i = 0; i < 4; i++) begin
            issue(FLOW_LOOP, 16'h0, 16'h0080, 16'h0, 16'h0);
        end

        // Asynchronous reset mid-flush with two stacked entries
        do_reset();
        issue(FLOW_CALL, 16'h0, 16'h0400, 16'h0021, 16'h0);
        issue(FLOW_CALL, 16'h0, 16'h0500, 16'h0022, 16'h0);
        cyc(1'b1, FLOW_JMP, 16'h0, 16'h0300, 16'h0, 16'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(FLOW_RET, 16'h0, 16'h0, 16'h0, 16'h0);
        issue(FLOW_LOOP, 16'h0, 16'h0080, 16'h0, 16'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dsp_branch_ctrl.md
# dsp_branch_ctrl

Registered branch-resolution unit for the DSP core, sitting between decode/ALU and fetch. It evaluates the decoded flow mode against the ALU result and drives a one-cycle jump request to fetch. It adds a parametrised return-address stack for CALL/RET, a hardware loop counter, and a fixed-length pipeline flush window after every taken jump.

## Interface
Parameters:
- DATA_W, 16, ALU result and loop-count width
- ADDR_W, 16, instruction address width
- DEPTH, 4, return-stack entries (≥1)
- FLUSH_CYCLES, 2, cycles flush/busy stay high after a taken jump (≥1)

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- valid_in  in  1  flow_mode/operands valid this cycle
- flow_mode  in  FLOW_MODE_LEN  decoded flow code (dsp_flow_pkg)
- alu_result  in  DATA_W  condition operand from ALU
- target_addr  in  ADDR_W  branch/jump/call target
- pc_next  in  ADDR_W  return address pushed by CALL
- loop_count  in  DATA_W  value loaded by LSET
- jump_flag  out  1  registered one-cycle jump request to fetch
- jump_addr  out  ADDR_W  registered jump target, valid while jump_flag=1
- flush  out  1  squash younger pipeline stages
- busy  out  1  unit in flush window; valid_in ignored
- stack_err  out  1  sticky return-stack overflow/underflow

## Operation
- An instruction is accepted when valid_in=1 and busy=0; otherwise inputs are ignored with no state change.
- Taken conditions per accepted mode:
  - NONE: never taken.
  - JMP: always taken; target_addr.
  - BEZ, BEQ: taken if alu_result==0 (BEQ relies on ALU subtraction).
  - BNEZ: taken if alu_result!=0.
  - BLTZ: taken if alu_result[DATA_W-1]=1.
  - CALL: push pc_next; taken to target_addr.
  - RET: pop; taken to the popped address.
  - LSET: loop_cnt <= loop_count; never taken.
  - LOOP: if loop_cnt!=0, then loop_cnt <= loop_cnt-1 and taken to target_addr; else not taken, loop_cnt stays 0.
- A not-taken resolution drives jump_flag=0; jump_addr holds its previous value.
- Undefined flow codes are treated as NONE.
- Return stack is LIFO, DEPTH entries, pointer 0..DEPTH.
  - CALL when full: no push, jump still taken, stack_err set.
  - RET when empty: not taken, stack_err set.
- stack_err clears only on reset.
- Taken jump starts flush counter at FLUSH_CYCLES; flush=busy=(counter!=0); counter decrements each cycle.

## Timing
- Reset values: jump_flag=0, jump_addr=0, flush=0, busy=0, stack_err=0, stack pointer=0, loop_cnt=0, flush counter=0. Reset mid-flush or mid-loop aborts immediately.
- Latency 1: an accepted instruction at edge N gives jump_flag/jump_addr at N+1, high exactly one cycle.
- flush/busy are high for cycles N+1 … N+FLUSH_CYCLES; valid_in is accepted again at N+FLUSH_CYCLES+1.
- Stack push/pop and loop_cnt updates are visible to an instruction accepted on the next cycle (back-to-back CALL then RET with FLUSH suppressed is impossible, since CALL always flushes).
- LSET followed directly by LOOP uses the newly loaded value.
- Arithmetic: loop_cnt is unsigned DATA_W and never wraps below 0. BLTZ uses the two's-complement sign bit.

## Structure
- dsp_flow_pkg holds FLOW_MODE_LEN=4 and the flow codes: NONE=0, JMP=1, BEZ=2, BNEZ=3, BEQ=4, BLTZ=5, CALL=6, RET=7, LSET=8, LOOP=9. It is shared with decode.
- Sub-module dsp_ret_stack (parameters DEPTH, ADDR_W) provides push/pop/full/empty/top. It is a register array with asynchronous clear.
- The top level holds the condition mux, loop counter, flush counter, and output registers.

## Test plan
- Reset then BNEZ with alu_result=0x0000 → jump_flag=0. Next, BNEZ with alu_result=0x0001, target 0x0040 → jump_flag=1 and jump_addr=0x0040 one cycle later; flush/busy high 2 cycles.
- valid_in held high during busy with JMP to 0x0100 → no second jump until the window ends; the instruction is accepted on the first non-busy cycle.
- CALL pc_next=0x0011 target=0x0200, then after flush RET → jump to 0x0011. A further RET on empty → jump_flag=0, stack_err=1 (sticky).
- DEPTH=4: five CALLs → all five taken, fifth not pushed, stack_err=1. Four RETs return the first four pc_next values in reverse order.
- LSET loop_count=3, then LOOP ×4 target=0x0080 → taken, taken, taken, not-taken; loop_cnt ends at 0.
- Assert rst_n low during a flush window and with the stack half full → all outputs 0 asynchronously. The first RET after release underflows.
